// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port SRAM between fetch and data ports, intercepts HTIF tohost stores and flags out-of-range accesses
module unified_mem_arbiter #(
  parameter int          MEM_SIZE_WORDS = 16384,
  parameter int          IDX_W          = 14,
  parameter logic [31:0] MEM_BASE       = 32'h80000000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h80001000,
  parameter int          MAX_WAIT       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req_valid,
  input  logic [31:0]      if_req_addr,
  output logic             if_req_ready,
  output logic             if_resp_valid,
  output logic [31:0]      if_resp_data,
  input  logic             d_req_valid,
  input  logic             d_req_we,
  input  logic [31:0]      d_req_addr,
  input  logic [31:0]      d_req_wdata,
  output logic             d_req_ready,
  output logic             d_resp_valid,
  output logic [31:0]      d_resp_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             tohost_valid,
  output logic [31:0]      tohost_data,
  output logic             err_oob
);
  typedef enum logic [2:0] {OWN_NONE, OWN_IF_MEM, OWN_IF_ZERO, OWN_D_MEM, OWN_D_ZERO} owner_e;
  localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + 33'(MEM_SIZE_WORDS) * 33'd4;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  owner_e owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic tohost_valid_q, tohost_valid_d, err_q, err_d;
  logic [31:0] tohost_data_q, tohost_data_d, addr;
  logic gnt_if, gnt_d, in_range, is_tohost, is_load;
  // arbitration, address decode, SRAM command and next-state
  always_comb begin
    gnt_if = !reset && if_req_valid && (starve_q == WAIT_MAX || !d_req_valid);
    gnt_d = !reset && d_req_valid && !gnt_if;
    addr = gnt_if ? if_req_addr : d_req_addr;
    in_range = addr >= MEM_BASE && {1'b0, addr} < MEM_END;
    is_tohost = gnt_d && d_req_we && d_req_addr == TOHOST_ADDR;
    is_load = gnt_if || (gnt_d && !d_req_we);
    mem_en = (gnt_if || gnt_d) && in_range && !is_tohost;
    mem_we = mem_en && gnt_d && d_req_we;
    mem_idx = mem_en ? IDX_W'((addr - MEM_BASE) >> 2) : '0;
    mem_wdata = mem_we ? d_req_wdata : '0;
    if_req_ready = gnt_if;
    d_req_ready = gnt_d;
    owner_d = !is_load ? OWN_NONE :
              gnt_if ? (in_range ? OWN_IF_MEM : OWN_IF_ZERO) :
                       (in_range ? OWN_D_MEM : OWN_D_ZERO);
    starve_d = (if_req_valid && !gnt_if) ? (starve_q == WAIT_MAX ? starve_q : starve_q + 4'd1) : 4'd0;
    tohost_valid_d = is_tohost;
    tohost_data_d = is_tohost ? d_req_wdata : tohost_data_q;
    err_d = err_q || ((gnt_if || gnt_d) && !in_range && !is_tohost);
  end
  // state registers; reset drops any in-flight response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      starve_q <= 4'd0;
      tohost_valid_q <= 1'b0;
      tohost_data_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      starve_q <= starve_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q <= tohost_data_d;
      err_q <= err_d;
    end
  end
  assign if_resp_valid = owner_q == OWN_IF_MEM || owner_q == OWN_IF_ZERO;
  assign if_resp_data = owner_q == OWN_IF_MEM ? mem_rdata : 32'h0;
  assign d_resp_valid = owner_q == OWN_D_MEM || owner_q == OWN_D_ZERO;
  assign d_resp_data = owner_q == OWN_D_MEM ? mem_rdata : 32'h0;
  assign tohost_valid = tohost_valid_q;
  assign tohost_data = tohost_data_q;
  assign err_oob = err_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench for the shared-memory arbiter
module tb_unified_mem_arbiter;
  localparam int SIZE = 16384;
  localparam int IDXW = 14;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam logic [31:0] TOHOST = 32'h80001000;
  localparam int MAXW = 4;
  typedef struct {int due; logic [31:0] data;} exp_t;
  logic clk = 0, reset = 1;
  logic if_req_valid = 0, d_req_valid = 0, d_req_we = 0;
  logic [31:0] if_req_addr = 0, d_req_addr = 0, d_req_wdata = 0;
  logic if_req_ready, if_resp_valid, d_req_ready, d_resp_valid;
  logic mem_en, mem_we, tohost_valid, err_oob;
  logic [31:0] if_resp_data, d_resp_data, mem_wdata, tohost_data;
  logic [31:0] mem_rdata = 0;
  logic [IDXW-1:0] mem_idx;
  logic [31:0] sram [SIZE];
  logic sram_ready = 0;
  logic [31:0] ref_mem [SIZE];
  exp_t if_q[$], d_q[$], th_q[$];
  int cyc = 0, checks = 0, errors = 0, denied = 0, err_due = 0;
  logic [31:0] exp_th = 0;
  logic gi = 0, gd = 0, if_rdy_seen = 0;

  unified_mem_arbiter #(.MEM_SIZE_WORDS(SIZE), .IDX_W(IDXW), .MEM_BASE(BASE),
                        .TOHOST_ADDR(TOHOST), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .tohost_valid(tohost_valid), .tohost_data(tohost_data),
    .err_oob(err_oob));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(int i);
    return i == 4 ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // synchronous SRAM with one-cycle read latency; preloaded on the first edge
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < SIZE; i++) sram[i] <= init_val(i);
      sram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_idx] <= mem_wdata;
      else mem_rdata <= sram[mem_idx];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // reference model: applies the arbitration and memory rules to the current request pair
  task automatic model_check();
    longint unsigned a;
    logic inr, th, ee, ew;
    int wi;
    gi = if_req_valid && (denied >= MAXW || !d_req_valid);
    gd = d_req_valid && !gi;
    if_rdy_seen = if_req_ready;
    chk("if_req_ready", 32'(if_req_ready), 32'(gi));
    chk("d_req_ready", 32'(d_req_ready), 32'(gd));
    a = gi ? 64'(if_req_addr) : 64'(d_req_addr);
    inr = a >= 64'(BASE) && a < 64'(BASE) + 64'(4 * SIZE);
    wi = inr ? int'((a - 64'(BASE)) / 4) : 0;
    th = gd && d_req_we && d_req_addr == TOHOST;
    ee = (gi || gd) && inr && !th;
    ew = ee && gd && d_req_we;
    chk("mem_en", 32'(mem_en), 32'(ee));
    chk("mem_we", 32'(mem_we), 32'(ew));
    if (ee) chk("mem_idx", 32'(mem_idx), 32'(wi));
    if (ew) chk("mem_wdata", mem_wdata, d_req_wdata);
    if ((gi || gd) && !inr && !th && err_due == 0) err_due = cyc + 1;
    if (gi) if_q.push_back('{cyc + 1, inr ? ref_mem[wi] : 32'h0});
    else if (th) th_q.push_back('{cyc + 1, d_req_wdata});
    else if (gd && !d_req_we) d_q.push_back('{cyc + 1, inr ? ref_mem[wi] : 32'h0});
    else if (gd && inr) ref_mem[wi] = d_req_wdata;
    denied = (if_req_valid && !gi) ? (denied < MAXW ? denied + 1 : MAXW) : 0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    if (gi) if_req_valid = 0;
    if (gd) d_req_valid = 0;
  endtask

  task automatic fetch(logic [31:0] a);
    if_req_valid = 1;
    if_req_addr = a;
  endtask

  task automatic dreq(logic we, logic [31:0] a, logic [31:0] wd);
    d_req_valid = 1;
    d_req_we = we;
    d_req_addr = a;
    d_req_wdata = wd;
  endtask

  task automatic do_reset();
    reset = 1;
    if_req_valid = 0;
    d_req_valid = 0;
    if_q.delete();
    d_q.delete();
    th_q.delete();
    denied = 0;
    err_due = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 80) return BASE + 32'(4 * $urandom_range(0, 15));
    if (r < 86) return TOHOST;
    if (r < 90) return BASE + 32'(4 * (SIZE - 1));
    if (r < 94) return BASE + 32'(4 * SIZE);
    if (r < 97) return BASE - 32'd4;
    return 32'h00001000;
  endfunction

  // monitor: compares every DUT response against the scoreboard queues
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    if (reset) begin
      exp_th = 0;
      chk("reset_flags", {26'h0, if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_en, mem_we} |
                         {30'h0, tohost_valid, err_oob}, 32'h0);
      chk("reset_data", if_resp_data | d_resp_data | tohost_data | mem_wdata | 32'(mem_idx), 32'h0);
    end else begin
      while (if_q.size() > 0 && if_q[0].due < cyc) void'(if_q.pop_front());
      ev = if_q.size() > 0 && if_q[0].due == cyc;
      chk("if_resp_valid", 32'(if_resp_valid), 32'(ev));
      if (ev) begin
        e = if_q.pop_front();
        if (if_resp_valid) chk("if_resp_data", if_resp_data, e.data);
      end
      while (d_q.size() > 0 && d_q[0].due < cyc) void'(d_q.pop_front());
      ev = d_q.size() > 0 && d_q[0].due == cyc;
      chk("d_resp_valid", 32'(d_resp_valid), 32'(ev));
      if (ev) begin
        e = d_q.pop_front();
        if (d_resp_valid) chk("d_resp_data", d_resp_data, e.data);
      end
      while (th_q.size() > 0 && th_q[0].due < cyc) void'(th_q.pop_front());
      ev = th_q.size() > 0 && th_q[0].due == cyc;
      chk("tohost_valid", 32'(tohost_valid), 32'(ev));
      if (ev) begin
        e = th_q.pop_front();
        exp_th = e.data;
      end
      chk("tohost_data", tohost_data, exp_th);
      chk("err_oob", 32'(err_oob), 32'(err_due != 0 && cyc >= err_due));
    end
  end

  initial begin
    int first;
    for (int i = 0; i < SIZE; i++) ref_mem[i] = init_val(i);
    do_reset();
    fetch(BASE + 32'h10);
    tick();
    tick();
    dreq(1, BASE + 32'h20, 32'h12345678);
    tick();
    dreq(0, BASE + 32'h20, 0);
    tick();
    tick();
    first = -1;
    fetch(BASE + 32'h100);
    for (int i = 0; i < 10; i++) begin
      if (!d_req_valid) dreq(0, BASE + 32'(4 * i), 0);
      tick();
      if (if_rdy_seen && first < 0) first = i;
    end
    chk("starve_win_cycle", 32'(first), 32'd4);
    tick();
    dreq(1, TOHOST, 32'h1);
    tick();
    tick();
    dreq(1, TOHOST, 32'h3);
    tick();
    tick();
    tick();
    dreq(0, 32'h7FFFFFFC, 0);
    tick();
    dreq(1, 32'h80010000, 32'h5);
    tick();
    repeat (3) tick();
    dreq(0, BASE + 32'h40, 0);
    @(negedge clk);
    model_check();
    #2;
    do_reset();
    fetch(BASE + 32'h10);
    tick();
    tick();
    for (int n = 0; n < 400; n++) begin
      if (!if_req_valid && $urandom_range(0, 9) < 6) fetch(rand_addr());
      if (!d_req_valid && $urandom_range(0, 9) < 7) dreq(1'($urandom_range(0, 1)), rand_addr(), $urandom());
      tick();
    end
    if_req_valid = 0;
    d_req_valid = 0;
    repeat (3) tick();
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_q.size()), 32'd0);
    chk("th_q_drained", 32'(th_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
